// File: rtl/hex_scan_driver_pkg.sv
// Shared glyph set and code names for the hex scan driver family.
// Glyphs are active-low, bit6=g .. bit0=a.
package hex_scan_driver_pkg;
  localparam int MAX_DIGITS = 8;

  localparam logic [6:0] GLYPH_0     = 7'b1000000;
  localparam logic [6:0] GLYPH_1     = 7'b1111001;
  localparam logic [6:0] GLYPH_2     = 7'b0100100;
  localparam logic [6:0] GLYPH_3     = 7'b0110000;
  localparam logic [6:0] GLYPH_4     = 7'b0011001;
  localparam logic [6:0] GLYPH_5     = 7'b0010010;
  localparam logic [6:0] GLYPH_6     = 7'b0000010;
  localparam logic [6:0] GLYPH_7     = 7'b1111000;
  localparam logic [6:0] GLYPH_8     = 7'b0000000;
  localparam logic [6:0] GLYPH_9     = 7'b0010000;
  localparam logic [6:0] GLYPH_A     = 7'b0001000;
  localparam logic [6:0] GLYPH_B     = 7'b0001100;
  localparam logic [6:0] GLYPH_C     = 7'b0111001;
  localparam logic [6:0] GLYPH_D     = 7'b0001111;
  localparam logic [6:0] GLYPH_E     = 7'b0111111;
  localparam logic [6:0] GLYPH_F     = 7'b1111111;
  localparam logic [6:0] GLYPH_BLANK = 7'h7F;

  localparam logic [3:0] CODE_P     = 4'hB;
  localparam logic [3:0] CODE_DASH  = 4'hE;
  localparam logic [3:0] CODE_BLANK = 4'hF;
endpackage

// File: rtl/hex_glyph_rom.sv
// 4-bit display code to active-low seven-segment glyph.
module hex_glyph_rom
  import hex_scan_driver_pkg::*;
(
  input  logic [3:0] code,
  output logic [6:0] glyph
);
  always_comb begin
    case (code)
      4'h0:      glyph = GLYPH_0;
      4'h1:      glyph = GLYPH_1;
      4'h2:      glyph = GLYPH_2;
      4'h3:      glyph = GLYPH_3;
      4'h4:      glyph = GLYPH_4;
      4'h5:      glyph = GLYPH_5;
      4'h6:      glyph = GLYPH_6;
      4'h7:      glyph = GLYPH_7;
      4'h8:      glyph = GLYPH_8;
      4'h9:      glyph = GLYPH_9;
      4'hA:      glyph = GLYPH_A;
      CODE_P:    glyph = GLYPH_B;
      4'hC:      glyph = GLYPH_C;
      4'hD:      glyph = GLYPH_D;
      CODE_DASH: glyph = GLYPH_E;
      default:   glyph = GLYPH_F;
    endcase
  end
endmodule

// File: rtl/hex_scan_driver.sv
// Multi-digit seven-segment driver: static per-digit bus plus scanned
// segment/digit-enable pair, with blinking and leading-zero blanking.
module hex_scan_driver
  import hex_scan_driver_pkg::*;
#(
  parameter int NUM_DIGITS  = 4,
  parameter int SCAN_DIV    = 50000,
  parameter int BLINK_TICKS = 250
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    en,
  input  logic                    load,
  input  logic [4*NUM_DIGITS-1:0] codes_in,
  input  logic [NUM_DIGITS-1:0]   blink_mask,
  input  logic                    lzb_en,
  output logic [7*NUM_DIGITS-1:0] HEX_ALL,
  output logic [6:0]              seg_n,
  output logic [NUM_DIGITS-1:0]   dig_n,
  output logic                    busy
);
  localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int PRE_W = $clog2(SCAN_DIV);
  localparam int BLK_W = (BLINK_TICKS > 1) ? $clog2(BLINK_TICKS) : 1;

  logic [NUM_DIGITS-1:0][3:0] codes, codes_nxt;
  logic [NUM_DIGITS-1:0]      mask, mask_nxt;
  logic                       lzb, lzb_nxt;
  logic [PRE_W-1:0]           pre, pre_nxt;
  logic [IDX_W-1:0]           idx, idx_nxt;
  logic [BLK_W-1:0]           bcnt, bcnt_nxt;
  logic                       phase, phase_nxt, tick;
  logic [NUM_DIGITS-1:0][6:0] glyph, eff;
  logic [NUM_DIGITS-1:0]      blank;
  logic [6:0]                 scan_glyph, scan_eff;

  always_comb begin
    codes_nxt = load ? codes_in : codes;
    mask_nxt  = load ? blink_mask : mask;
    lzb_nxt   = load ? lzb_en : lzb;
    tick      = en && (pre == PRE_W'(SCAN_DIV - 1));
    pre_nxt   = pre;
    idx_nxt   = idx;
    bcnt_nxt  = bcnt;
    phase_nxt = phase;
    if (en) pre_nxt = tick ? '0 : pre + 1'b1;
    if (tick) begin
      idx_nxt = (idx == IDX_W'(NUM_DIGITS - 1)) ? '0 : idx + 1'b1;
      if (bcnt == BLK_W'(BLINK_TICKS - 1)) begin
        bcnt_nxt  = '0;
        phase_nxt = ~phase;
      end else begin
        bcnt_nxt = bcnt + 1'b1;
      end
    end
  end

  for (genvar d = 0; d < NUM_DIGITS; d++) begin : g_dig
    hex_glyph_rom u_rom (.code(codes_nxt[d]), .glyph(glyph[d]));
  end

  hex_glyph_rom u_scan_rom (.code(codes_nxt[idx_nxt]), .glyph(scan_glyph));

  // Walk from the top digit down so "all higher codes zero" is a running AND.
  always_comb begin
    logic run;
    run   = 1'b1;
    blank = '0;
    eff   = '0;
    for (int d = NUM_DIGITS - 1; d >= 0; d--) begin
      run      = run && (codes_nxt[d] == 4'h0);
      blank[d] = (mask_nxt[d] && phase_nxt) || (lzb_nxt && (d > 0) && run);
      eff[d]   = blank[d] ? GLYPH_BLANK : glyph[d];
    end
    scan_eff = blank[idx_nxt] ? GLYPH_BLANK : scan_glyph;
  end

  // Outputs are registered from next-state values so a load or tick is
  // visible on the very next cycle, and seg_n/dig_n switch together.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      codes   <= {NUM_DIGITS{CODE_BLANK}};
      mask    <= '0;
      lzb     <= 1'b0;
      pre     <= '0;
      idx     <= '0;
      bcnt    <= '0;
      phase   <= 1'b0;
      busy    <= 1'b0;
      HEX_ALL <= '1;
      seg_n   <= GLYPH_BLANK;
      dig_n   <= '1;
    end else begin
      codes   <= codes_nxt;
      mask    <= mask_nxt;
      lzb     <= lzb_nxt;
      pre     <= pre_nxt;
      idx     <= idx_nxt;
      bcnt    <= bcnt_nxt;
      phase   <= phase_nxt;
      busy    <= load;
      HEX_ALL <= en ? eff : '1;
      seg_n   <= en ? scan_eff : GLYPH_BLANK;
      dig_n   <= en ? ~(NUM_DIGITS'(1) << idx_nxt) : '1;
    end
  end
endmodule

// File: tb/tb_hex_scan_driver.sv
// Directed bench for hex_scan_driver at NUM_DIGITS=4, SCAN_DIV=4, BLINK_TICKS=2.
module tb_hex_scan_driver;
  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        en = 1'b0;
  logic        load = 1'b0;
  logic [15:0] codes_in = '0;
  logic [3:0]  blink_mask = '0;
  logic        lzb_en = 1'b0;
  logic [27:0] HEX_ALL;
  logic [6:0]  seg_n;
  logic [3:0]  dig_n;
  logic        busy;

  int checks = 0;
  int errors = 0;

  hex_scan_driver #(.NUM_DIGITS(4), .SCAN_DIV(4), .BLINK_TICKS(2)) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .load(load), .codes_in(codes_in),
    .blink_mask(blink_mask), .lzb_en(lzb_en), .HEX_ALL(HEX_ALL),
    .seg_n(seg_n), .dig_n(dig_n), .busy(busy)
  );

  always #5 clk = ~clk;

  function automatic logic [6:0] gl(input logic [3:0] c);
    case (c)
      4'h0: return 7'b1000000;  4'h1: return 7'b1111001;
      4'h2: return 7'b0100100;  4'h3: return 7'b0110000;
      4'h4: return 7'b0011001;  4'h5: return 7'b0010010;
      4'h6: return 7'b0000010;  4'h7: return 7'b1111000;
      4'h8: return 7'b0000000;  4'h9: return 7'b0010000;
      4'hA: return 7'b0001000;  4'hB: return 7'b0001100;
      4'hC: return 7'b0111001;  4'hD: return 7'b0001111;
      4'hE: return 7'b0111111;  default: return 7'b1111111;
    endcase
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0; en = 1'b0; load = 1'b0;
    codes_in = '0; blink_mask = '0; lzb_en = 1'b0;
    step(); step();
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (HEX_ALL !== 28'hFFFFFFF || seg_n !== 7'h7F || dig_n !== 4'hF || busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_async: HEX=%h seg=%h dig=%b busy=%b", HEX_ALL, seg_n, dig_n, busy);
    end
    step(); step();
    rst_n = 1'b1;
    step(); step();
    checks++;
    if (HEX_ALL !== 28'hFFFFFFF) begin errors++; $display("FAIL reset_hex: got %h want fffffff", HEX_ALL); end
    checks++;
    if (seg_n !== 7'h7F) begin errors++; $display("FAIL reset_seg: got %h want 7f", seg_n); end
    checks++;
    if (dig_n !== 4'hF) begin errors++; $display("FAIL reset_dig: got %b want 1111", dig_n); end
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
  endtask

  task automatic test_scan();
    logic [15:0] c;
    int ix;
    c = 16'h1234;
    do_reset();
    en = 1'b1; load = 1'b1; codes_in = c;
    step();  // E1
    load = 1'b0;
    checks++;
    if (busy !== 1'b1) begin errors++; $display("FAIL scan_busy_hi: got %b want 1", busy); end
    checks++;
    if (HEX_ALL !== {gl(4'h1), gl(4'h2), gl(4'h3), gl(4'h4)})
      begin errors++; $display("FAIL scan_hex: got %h", HEX_ALL); end
    checks++;
    if (HEX_ALL[6:0] !== 7'b0011001) begin errors++; $display("FAIL scan_d0: got %b want 0011001", HEX_ALL[6:0]); end
    checks++;
    if (dig_n !== 4'b1110 || seg_n !== 7'b0011001)
      begin errors++; $display("FAIL scan_first: dig=%b seg=%b want 1110/0011001", dig_n, seg_n); end
    step();  // E2
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL scan_busy_lo: got %b want 0", busy); end
    for (int k = 3; k <= 17; k++) begin
      step();
      ix = (k / 4) % 4;
      checks++;
      if (dig_n !== ~(4'b0001 << ix) || seg_n !== gl(c[4*ix +: 4])) begin
        errors++;
        $display("FAIL scan_cycle k=%0d: dig=%b seg=%b want dig=%b seg=%b",
                 k, dig_n, seg_n, ~(4'b0001 << ix), gl(c[4*ix +: 4]));
      end
    end
  endtask

  task automatic test_lzb();
    do_reset();
    en = 1'b1; load = 1'b1; codes_in = 16'h0050; lzb_en = 1'b1;
    step();  // E1
    checks++;
    if (HEX_ALL !== {7'h7F, 7'h7F, 7'b0010010, 7'b1000000})
      begin errors++; $display("FAIL lzb_0050: got %h", HEX_ALL); end
    checks++;
    if (seg_n !== 7'b1000000) begin errors++; $display("FAIL lzb_seg0: got %b want 1000000", seg_n); end
    codes_in = 16'h0000;
    step();  // E2, back-to-back load
    load = 1'b0;
    checks++;
    if (busy !== 1'b1) begin errors++; $display("FAIL lzb_b2b_busy: got %b want 1", busy); end
    checks++;
    if (HEX_ALL !== {7'h7F, 7'h7F, 7'h7F, 7'b1000000})
      begin errors++; $display("FAIL lzb_0000: got %h", HEX_ALL); end
    step(); step();  // E4: index 1
    checks++;
    if (dig_n !== 4'b1101 || seg_n !== 7'h7F)
      begin errors++; $display("FAIL lzb_scan1: dig=%b seg=%h want 1101/7f", dig_n, seg_n); end
  endtask

  task automatic test_blink();
    logic [27:0] exp_hex;
    logic [6:0]  exp_seg;
    int ix, ph;
    do_reset();
    en = 1'b1; load = 1'b1; codes_in = 16'h8888; blink_mask = 4'b0101;
    step();  // E1
    load = 1'b0;
    for (int k = 1; k <= 24; k++) begin
      if (k > 1) step();
      ph = (k / 8) % 2;
      ix = (k / 4) % 4;
      exp_hex = (ph == 1) ? 28'h01FC07F : 28'h0000000;
      exp_seg = (ph == 1 && (ix == 0 || ix == 2)) ? 7'h7F : 7'h00;
      checks++;
      if (HEX_ALL !== exp_hex || seg_n !== exp_seg || dig_n !== ~(4'b0001 << ix)) begin
        errors++;
        $display("FAIL blink k=%0d: HEX=%h seg=%h dig=%b want %h/%h/%b",
                 k, HEX_ALL, seg_n, dig_n, exp_hex, exp_seg, ~(4'b0001 << ix));
      end
    end
  endtask

  task automatic test_enable_hold();
    do_reset();
    en = 1'b1; load = 1'b1; codes_in = 16'h1234;
    step();  // E1
    load = 1'b0;
    for (int k = 2; k <= 9; k++) step();  // after E9: index 2, prescaler 1
    checks++;
    if (dig_n !== 4'b1011) begin errors++; $display("FAIL hold_pre: dig=%b want 1011", dig_n); end
    en = 1'b0;
    load = 1'b1; codes_in = 16'h5678;
    step();
    load = 1'b0;
    checks++;
    if (busy !== 1'b1 || HEX_ALL !== 28'hFFFFFFF || seg_n !== 7'h7F || dig_n !== 4'hF)
      begin errors++; $display("FAIL hold_blank: busy=%b HEX=%h seg=%h dig=%b", busy, HEX_ALL, seg_n, dig_n); end
    for (int k = 0; k < 5; k++) step();
    checks++;
    if (HEX_ALL !== 28'hFFFFFFF || dig_n !== 4'hF)
      begin errors++; $display("FAIL hold_stay: HEX=%h dig=%b", HEX_ALL, dig_n); end
    en = 1'b1;
    step();
    checks++;
    if (dig_n !== 4'b1011 || seg_n !== gl(4'h6))
      begin errors++; $display("FAIL hold_resume1: dig=%b seg=%b want 1011/%b", dig_n, seg_n, gl(4'h6)); end
    step();
    checks++;
    if (dig_n !== 4'b1011) begin errors++; $display("FAIL hold_resume2: dig=%b want 1011", dig_n); end
    step();
    checks++;
    if (dig_n !== 4'b0111 || seg_n !== gl(4'h5))
      begin errors++; $display("FAIL hold_resume3: dig=%b seg=%b want 0111/%b", dig_n, seg_n, gl(4'h5)); end
  endtask

  task automatic test_tick_load_reset();
    do_reset();
    en = 1'b1; load = 1'b1; codes_in = 16'h1234;
    step();  // E1
    load = 1'b0;
    step(); step();  // E3
    load = 1'b1; codes_in = 16'hABCD; blink_mask = 4'b0001;
    step();  // E4: tick and load together
    load = 1'b0;
    checks++;
    if (dig_n !== 4'b1101 || seg_n !== gl(4'hC) || busy !== 1'b1)
      begin errors++; $display("FAIL tick_load: dig=%b seg=%b busy=%b want 1101/%b/1", dig_n, seg_n, busy, gl(4'hC)); end
    for (int k = 5; k <= 9; k++) step();  // after E9: phase 1, index 2
    checks++;
    if (HEX_ALL !== {gl(4'hA), gl(4'hB), gl(4'hC), 7'h7F} || dig_n !== 4'b1011)
      begin errors++; $display("FAIL mid_blink: HEX=%h dig=%b", HEX_ALL, dig_n); end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (HEX_ALL !== 28'hFFFFFFF || seg_n !== 7'h7F || dig_n !== 4'hF || busy !== 1'b0)
      begin errors++; $display("FAIL reset_mid: HEX=%h seg=%h dig=%b busy=%b", HEX_ALL, seg_n, dig_n, busy); end
    step();
    rst_n = 1'b1;
    load = 1'b1; codes_in = 16'hABCD; blink_mask = 4'b0001;
    step();
    load = 1'b0;
    checks++;
    if (dig_n !== 4'b1110 || HEX_ALL !== {gl(4'hA), gl(4'hB), gl(4'hC), gl(4'hD)})
      begin errors++; $display("FAIL reset_restart: dig=%b HEX=%h", dig_n, HEX_ALL); end
  endtask

  initial begin
    test_reset();
    test_scan();
    test_lzb();
    test_blink();
    test_enable_hold();
    test_tick_load_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/hex_scan_driver.md
Name: hex_scan_driver

Overview:
Parametrised multi-digit seven-segment driver. It latches a packed vector of 4-bit display codes and decodes each through the team's 16-entry glyph set. Decoded glyphs go out two ways: a registered static bus for boards with one HEX display per digit, and a time-multiplexed segment/digit-enable pair for scanned displays. Adds per-digit blinking, leading-zero blanking and a load handshake.

Parameters:
NUM_DIGITS, 4, digit count (1..8)
SCAN_DIV, 50000, clk cycles per scan tick (>=2)
BLINK_TICKS, 250, scan ticks per blink half-period (>=1)

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
en  in  1  1 = display active; 0 = freeze scan/blink counters, blank outputs
load  in  1  single-cycle strobe; captures codes_in, blink_mask, lzb_en
codes_in  in  4*NUM_DIGITS  code per digit, digit 0 in [3:0]
blink_mask  in  NUM_DIGITS  1 = digit blinks
lzb_en  in  1  1 = leading-zero blanking
HEX_ALL  out  7*NUM_DIGITS  static segments, active-low, digit d in [7d+6:7d], bit6=g .. bit0=a
seg_n  out  7  scanned segments, active-low, same bit order
dig_n  out  NUM_DIGITS  scanned digit enables, one-hot active-low
busy  out  1  high the cycle after load (capture in progress)

Behaviour:
- Glyph set (code -> g..a):
  0 1000000, 1 1111001, 2 0100100, 3 0110000, 4 0011001, 5 0010010, 6 0000010, 7 1111000, 8 0000000, 9 0010000, A 0001000, B "P" 0001100, C "-/" 0111001, D "/-" 0001111, E "-" 0111111, F blank 1111111.
- Reset (async, rst_n=0):
  - code registers = F (blank); blink_mask and lzb_en regs = 0.
  - Prescaler = 0, digit index = 0, blink counter = 0, blink_phase = 0.
  - HEX_ALL all 1s, seg_n = 7'h7F, dig_n all 1s, busy = 0.
- Load:
  - On a clk edge with load=1, all three inputs are captured.
  - busy=1 for exactly the next cycle; outputs reflect new data on that same cycle (1-cycle latency).
  - A load while busy=1 is accepted (back-to-back loads allowed; last wins).
- Prescaler: counts 0..SCAN_DIV-1 while en=1; tick = (count==SCAN_DIV-1); wraps to 0.
- Digit index: on tick, advances 0,1,..,NUM_DIGITS-1, then wraps to 0.
- Blink counter: on tick, counts 0..BLINK_TICKS-1; on wrap, toggles blink_phase.
- Effective glyph for digit d is blank if any of:
  - blink_mask[d] && blink_phase;
  - lzb_en && d>0 && codes[NUM_DIGITS-1..d] are all 0.
  Otherwise it is the decoded glyph. Digit 0 is never zero-blanked.
- Output registers:
  - HEX_ALL = effective glyphs for all digits.
  - seg_n = effective glyph[index]; dig_n = ~(1<<index).
  - Both updated every cycle from the post-edge state.
- en=0: counters hold, HEX_ALL/seg_n blank, dig_n all 1s; loads still captured. Returning to en=1 resumes from held counts.
- Simultaneous tick and load: both take effect; next-cycle outputs use the new codes at the new index.
- Reset mid-scan or mid-blink: immediate blank, counters restart from 0.
- No ghosting: seg_n and dig_n are registered in the same cycle, so they change together.

Decomposition:
- Shared package/header: glyph constants GLYPH_0..GLYPH_F, GLYPH_BLANK = 7'h7F, code names CODE_P, CODE_DASH, CODE_BLANK; max-digit constant 8.
- One combinational sub-module, hex_glyph_rom (4-bit code -> 7-bit active-low glyph), instantiated NUM_DIGITS times for the static bus plus once for the scanned path.
- Counters, blanking logic and output registers live in the top.

Test Plan (NUM_DIGITS=4, SCAN_DIV=4, BLINK_TICKS=2):
1. Reset, then release with no load -> HEX_ALL=28'hFFFFFFF, seg_n=7F, dig_n=4'hF, busy=0.
2. en=1, load codes_in=16'h1234, lzb_en=0 -> next cycle busy=1 and HEX_ALL digit0=0011001 ("4"); seg_n/dig_n cycle 4 clks per digit, dig_n 1110->1101->1011->0111->1110 with matching glyphs.
3. load codes_in=16'h0050, lzb_en=1 -> digits 3,2 blank; digit1=0010010; digit0=1000000 (not blanked). Load 16'h0000 -> only digit0 shows "0".
4. load 16'h8888, blink_mask=4'b0101 -> digits 0 and 2 blank during alternate 8-clk windows (2 ticks); digits 1 and 3 stay 0000000.
5. Drop en to 0 mid-scan at index 2 -> outputs blank, counters hold; raise en -> scan resumes at index 2 with the same prescaler count.
6. Assert load on a tick edge, then pulse rst_n low mid-blink -> new codes visible with advanced index next cycle; on reset all outputs blank immediately and index/blink_phase return to 0.
